usb_rx_packet_check: RTL and testbench
======================================

Name: usb_rx_packet_check

Overview:
- Receive-side packet stage between the USB PHY/deserializer byte stream and the endpoint buffer logic.
- Decodes and validates the PID byte and classifies the packet as token, data, handshake or special.
- For data packets it computes CRC16 (x^16+x^15+x^2+1, LSB-first, init 0xFFFF), strips the two CRC bytes through a 2-byte delay line, forwards only payload bytes downstream, and reports a per-packet status strobe.

Parameters:
- MAX_PAYLOAD, 1024, maximum data payload bytes accepted; more is a length error.
- CNT_W, 11, width of the payload byte counter; must satisfy 2^CNT_W > MAX_PAYLOAD.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte, LSB is first bit on the wire.
- rx_valid  in  1  rx_data valid this cycle.
- rx_sop  in  1  with rx_valid: this byte is the PID (first byte of a packet).
- rx_eop  in  1  end of packet; strobe with no data, after the last byte.
- rx_err  in  1  PHY error (bit-stuff/sync); the packet is aborted.
- pid  out  4  latched PID[3:0].
- pid_valid  out  1  1-cycle strobe, PID decoded and check passed.
- out_data  out  8  payload byte.
- out_valid  out  1  payload byte strobe.
- byte_count  out  CNT_W  payload bytes forwarded in the current or last packet.
- pkt_done  out  1  1-cycle strobe; the status outputs are valid this cycle.
- pkt_ok  out  1  packet good; meaningful only with pkt_done.
- pid_err, crc_err, len_err, phy_err  out  1 each  status flags; held from pkt_done until the next rx_sop.

Behaviour:
- Reset values:
  - All outputs 0; pid = 0; byte_count = 0.
  - State IDLE; CRC register 0xFFFF; delay line empty.
- States: IDLE, TOKEN, DATA, HSHK, DRAIN.
- IDLE:
  - Bytes without rx_sop are ignored.
  - On rx_valid & rx_sop: clear all flags and byte_count, and set the CRC register to 0xFFFF.
  - If rx_data[3:0] != ~rx_data[7:4]: set pid_err and go to DRAIN.
  - Otherwise latch pid, pulse pid_valid on the next cycle, and branch on the PID:
    - Token (0x1, 0x9, 0x5, 0xD) -> TOKEN.
    - Data (0x3, 0xB, 0x7, 0xF) -> DATA.
    - Handshake (0x2, 0xA, 0xE, 0x6) and special (0xC, 0x8, 0x4, 0x0) -> HSHK.
- TOKEN:
  - Counts the bytes after the PID. They are not forwarded, and CRC5 is not checked here.
  - On rx_eop: len_err unless exactly 2 bytes were received.
- HSHK: on rx_eop, len_err if any byte followed the PID.
- DATA:
  - 2-entry delay line (d0 newest, d1 oldest).
  - Each accepted byte shifts in. Once the line is full, the byte shifted out of d1 is:
    - presented on out_data with out_valid on the next cycle (latency: byte k appears 1 cycle after byte k+2 is accepted);
    - folded into the CRC16 register in the same cycle;
    - counted in byte_count.
  - Once byte_count reaches MAX_PAYLOAD, further shifted-out bytes set len_err and are neither forwarded nor counted.
  - On rx_eop:
    - Fewer than 2 bytes after the PID: len_err.
    - Otherwise crc_err if {d0,d1} != ~crc_reg (the CRC is transmitted low byte first, inverted).
- pkt_done:
  - Asserts the cycle after rx_eop, or the cycle after the abort.
  - pkt_ok = no flag set. Then return to IDLE.
- DRAIN: discard bytes until rx_eop, then pkt_done with pid_err.
- Abort conditions:
  - rx_err in any non-IDLE state: phy_err, pkt_done next cycle, return to IDLE. Bytes still in the delay line are never forwarded.
  - rx_sop with rx_valid in a non-IDLE state: terminate the current packet (phy_err, pkt_done next cycle). The new byte is processed as a fresh PID in the same cycle, so the status flags of the terminated packet are reported, then cleared.
- Simultaneous rx_valid and rx_eop: the byte is accepted first, then eop is evaluated including it.
- rx_eop or rx_err while in IDLE: ignored.
- rst mid-packet: everything returns to reset values. No pkt_done is issued.

Test Plan:
- DATA0 with zero-length payload, bytes C3,00,00 then eop -> pid_valid with pid=3; no out_valid; pkt_done with pkt_ok=1, byte_count=0.
- DATA1 with payload 00,01,02,03 plus a CRC from the bench model -> out_data sequence 00,01,02,03, each 1 cycle after byte+2 is accepted; pkt_ok=1, byte_count=4. Flip one bit of a CRC byte -> crc_err=1, pkt_ok=0, payload still forwarded.
- ACK, byte D2 then eop -> pid=2, pkt_ok=1. Byte D3 (PID check fails) -> pid_err=1, no pid_valid, pkt_done after eop.
- IN token 69,XX,YY then eop -> pkt_ok=1, no out_valid. The same token with 1 trailing byte -> len_err=1.
- MAX_PAYLOAD=4, DATA0 with 6 payload bytes plus CRC -> only 4 out_valid; len_err=1, byte_count=4.
- rx_err after the 3rd payload byte -> phy_err=1, pkt_done next cycle, exactly 1 out_valid seen. rx_sop mid-DATA -> old packet reports phy_err and the new PID is decoded cleanly.

Source files
------------

// File: rtl/usb_rx_packet_check.sv
// USB receive packet stage: PID decode/check, packet classification, CRC16 check
// and CRC stripping for data packets, per-packet status strobe.
module usb_rx_packet_check #(
  parameter int MAX_PAYLOAD = 1024,
  parameter int CNT_W       = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  input  logic             rx_sop_i,
  input  logic             rx_eop_i,
  input  logic             rx_err_i,
  output logic [3:0]       pid_o,
  output logic             pid_valid_o,
  output logic [7:0]       out_data_o,
  output logic             out_valid_o,
  output logic [CNT_W-1:0] byte_count_o,
  output logic             pkt_done_o,
  output logic             pkt_ok_o,
  output logic             pid_err_o,
  output logic             crc_err_o,
  output logic             len_err_o,
  output logic             phy_err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TOKEN = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_HSHK  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // flag vector bit positions: {pid, crc, len, phy}
  localparam int F_PID = 3;
  localparam int F_CRC = 2;
  localparam int F_LEN = 1;
  localparam int F_PHY = 0;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAYLOAD);

  logic [2:0]       state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic             pid_valid_q, pid_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic [3:0]       rep_q, rep_d;
  logic [3:0]       wrk_q, wrk_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       d0_q, d0_d;
  logic [7:0]       d1_q, d1_d;
  logic [1:0]       fill_q, fill_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             finish;
  logic             start;

  // Reflected CRC16 (poly 0x8005 -> 0xA001), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    pid_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    bcnt_d      = bcnt_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    rep_d       = rep_q;
    wrk_d       = wrk_q;
    crc_d       = crc_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    finish      = 1'b0;
    start       = rx_valid_i & rx_sop_i;

    if (state_q != S_IDLE) begin
      if (rx_err_i) begin
        wrk_d[F_PHY] = 1'b1;
        finish       = 1'b1;
        start        = 1'b0;
      end else if (start) begin
        wrk_d[F_PHY] = 1'b1;
        finish       = 1'b1;
      end else begin
        case (state_q)
          S_TOKEN, S_HSHK: begin
            if (rx_valid_i && cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
            if (rx_eop_i) begin
              if ((state_q == S_TOKEN) ? (cnt_d != 2'd2) : (cnt_d != 2'd0))
                wrk_d[F_LEN] = 1'b1;
              finish = 1'b1;
            end
          end
          S_DATA: begin
            // byte leaving d1 is payload; the last two bytes stay behind as CRC
            if (rx_valid_i) begin
              if (fill_q == 2'd2) begin
                crc_d = crc16_byte(crc_q, d1_q);
                if (bcnt_q == MAX_CNT) begin
                  wrk_d[F_LEN] = 1'b1;
                end else begin
                  out_data_d  = d1_q;
                  out_valid_d = 1'b1;
                  bcnt_d      = bcnt_q + CNT_W'(1);
                end
              end else begin
                fill_d = fill_q + 2'd1;
              end
              d1_d = d0_q;
              d0_d = rx_data_i;
            end
            if (rx_eop_i) begin
              if (fill_d != 2'd2)
                wrk_d[F_LEN] = 1'b1;
              else if ({d0_d, d1_d} != ~crc_d)
                wrk_d[F_CRC] = 1'b1;
              finish = 1'b1;
            end
          end
          default: begin
            if (rx_eop_i) finish = 1'b1;
          end
        endcase
      end
    end

    if (finish) begin
      done_d  = 1'b1;
      rep_d   = wrk_d;
      ok_d    = ~|wrk_d;
      state_d = S_IDLE;
    end

    // a terminated packet still reports its flags this cycle; clear them otherwise
    if (start) begin
      wrk_d  = '0;
      bcnt_d = '0;
      crc_d  = 16'hFFFF;
      fill_d = 2'd0;
      cnt_d  = 2'd0;
      if (!finish) rep_d = '0;
      if (rx_data_i[3:0] != ~rx_data_i[7:4]) begin
        wrk_d[F_PID] = 1'b1;
        state_d      = S_DRAIN;
      end else begin
        pid_d       = rx_data_i[3:0];
        pid_valid_d = 1'b1;
        case (rx_data_i[1:0])
          2'b01:   state_d = S_TOKEN;
          2'b11:   state_d = S_DATA;
          default: state_d = S_HSHK;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pid_q       <= 4'h0;
      pid_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      bcnt_q      <= '0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      rep_q       <= 4'h0;
      wrk_q       <= 4'h0;
      crc_q       <= 16'hFFFF;
      d0_q        <= 8'h00;
      d1_q        <= 8'h00;
      fill_q      <= 2'd0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      pid_valid_q <= pid_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      bcnt_q      <= bcnt_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      rep_q       <= rep_d;
      wrk_q       <= wrk_d;
      crc_q       <= crc_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pid_o        = pid_q;
  assign pid_valid_o  = pid_valid_q;
  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign byte_count_o = bcnt_q;
  assign pkt_done_o   = done_q;
  assign pkt_ok_o     = ok_q;
  assign pid_err_o    = rep_q[F_PID];
  assign crc_err_o    = rep_q[F_CRC];
  assign len_err_o    = rep_q[F_LEN];
  assign phy_err_o    = rep_q[F_PHY];

endmodule

// File: tb/tb_usb_rx_packet_check.sv
// Scoreboard bench for usb_rx_packet_check: expected PIDs, payload bytes and
// packet status are queued as stimulus is driven and matched against DUT strobes.
module tb_usb_rx_packet_check;

  localparam int MAXP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_err = 1'b0;
  logic [3:0] pid;
  logic       pid_valid, out_valid, pkt_done, pkt_ok;
  logic [7:0] out_data;
  logic [2:0] byte_count;
  logic       pid_err, crc_err, len_err, phy_err;

  usb_rx_packet_check #(.MAX_PAYLOAD(MAXP), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_sop_i(rx_sop), .rx_eop_i(rx_eop), .rx_err_i(rx_err),
    .pid_o(pid), .pid_valid_o(pid_valid), .out_data_o(out_data), .out_valid_o(out_valid),
    .byte_count_o(byte_count), .pkt_done_o(pkt_done), .pkt_ok_o(pkt_ok),
    .pid_err_o(pid_err), .crc_err_o(crc_err), .len_err_o(len_err), .phy_err_o(phy_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int data; int cyc; } exp_t;
  typedef struct { int flags; int ok; int bc; int cyc; } done_t;

  exp_t  outq[$];
  exp_t  pidq[$];
  done_t doneq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t  mo, mp;
  done_t md;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (outq.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          mo = outq.pop_front();
          chk("out_data", int'(out_data), mo.data);
          chk("out_cycle", cyc, mo.cyc);
        end
      end
      if (pid_valid) begin
        if (pidq.size() == 0) chk("pid_unexpected", 1, 0);
        else begin
          mp = pidq.pop_front();
          chk("pid", int'(pid), mp.data);
          chk("pid_cycle", cyc, mp.cyc);
        end
      end
      if (pkt_done) begin
        if (doneq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          md = doneq.pop_front();
          chk("done_flags", int'({pid_err, crc_err, len_err, phy_err}), md.flags);
          chk("done_ok", int'(pkt_ok), md.ok);
          if (md.bc >= 0) chk("done_bcnt", int'(byte_count), md.bc);
          chk("done_cycle", cyc, md.cyc);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic s, input logic e, input logic r,
                       input logic [7:0] d);
    rx_valid = v; rx_sop = s; rx_eop = e; rx_err = r; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
  endtask

  task automatic push_done(input int flags, input int bc);
    done_t d;
    d.flags = flags; d.ok = (flags == 0) ? 1 : 0; d.bc = bc; d.cyc = cyc;
    doneq.push_back(d);
  endtask

  task automatic push_pid(input logic [7:0] pb);
    exp_t e;
    e.data = int'(pb[3:0]); e.cyc = cyc;
    pidq.push_back(e);
  endtask

  // serial LFSR form of the USB CRC16, one bit at a time
  function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  // data packet: n payload bytes base, base+1, ...; abort_at = wire index replaced by rx_err
  task automatic send_data(input logic [7:0] pb, input logic [7:0] base, input int n,
                           input bit flip, input int abort_at, input bit eop_last);
    logic [7:0]  w[$];
    logic [15:0] c;
    logic [7:0]  b;
    exp_t        e;
    int          fwd;
    bit          last;
    c = 16'hFFFF;
    w = {};
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      w.push_back(b);
      c = crc_bits(c, b);
    end
    c = ~c;
    w.push_back(c[7:0] ^ (flip ? 8'h10 : 8'h00));
    w.push_back(c[15:8]);
    fwd = 0;
    drive(1, 1, 0, 0, pb);
    push_pid(pb);
    for (int i = 0; i < w.size(); i++) begin
      if (i == abort_at) begin
        drive(0, 0, 0, 1, 8'h00);
        push_done(4'b0001, fwd);
        return;
      end
      last = eop_last && (i == w.size() - 1);
      drive(1, 0, last, 0, w[i]);
      if (i >= 2 && (i - 2) < n && fwd < MAXP) begin
        e.data = int'(w[i-2]); e.cyc = cyc;
        outq.push_back(e);
        fwd++;
      end
    end
    if (!eop_last) drive(0, 0, 1, 0, 8'h00);
    push_done(((n > MAXP) ? 4'b0010 : 4'b0000) | (flip ? 4'b0100 : 4'b0000), fwd);
  endtask

  // token / handshake / bad-PID packet with nextra bytes after the PID
  task automatic send_short(input logic [7:0] pb, input int nextra, input int flags);
    drive(1, 1, 0, 0, pb);
    if (pb[3:0] == ~pb[7:4]) push_pid(pb);
    for (int i = 0; i < nextra; i++) drive(1, 0, 0, 0, 8'h5A + 8'(i));
    drive(0, 0, 1, 0, 8'h00);
    push_done(flags, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    idle(3);
    chk("rst_outs", int'({pid, pid_valid, out_valid, byte_count, pkt_done, pkt_ok}), 0);
    chk("rst_flags", int'({pid_err, crc_err, len_err, phy_err}), 0);
    rst = 1'b0;
    idle(2);

    send_data(8'hC3, 8'h00, 0, 0, -1, 0);       // DATA0, zero length
    idle(2);
    send_data(8'h4B, 8'h00, 4, 0, -1, 1);       // DATA1 00..03, eop with last byte
    idle(2);
    send_data(8'h4B, 8'h00, 4, 1, -1, 0);       // CRC bit flipped
    idle(2);
    chk("crc_err_held", int'(crc_err), 1);
    send_short(8'hD2, 0, 0);                    // ACK
    idle(1);
    send_short(8'hD3, 1, 4'b1000);              // bad PID, drained
    idle(1);
    send_short(8'h69, 2, 0);                    // IN token
    idle(1);
    send_short(8'h69, 1, 4'b0010);
    idle(1);
    send_short(8'h69, 3, 4'b0010);
    idle(1);
    send_short(8'hD2, 1, 4'b0010);              // handshake with trailing byte
    idle(1);
    send_data(8'hC3, 8'h10, 6, 0, -1, 0);       // over MAX_PAYLOAD
    idle(2);
    send_data(8'hC3, 8'h20, 4, 0, 3, 0);        // rx_err after 3rd payload byte
    idle(2);

    // rx_sop mid-DATA: old packet aborted, new ACK decoded cleanly
    drive(1, 1, 0, 0, 8'hC3); push_pid(8'hC3);
    drive(1, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h01);
    drive(1, 1, 0, 0, 8'hD2);
    push_done(4'b0001, -1); push_pid(8'hD2);
    drive(0, 0, 1, 0, 8'h00); push_done(0, 0);
    idle(2);

    // reset mid-packet: no pkt_done, outputs back to reset values
    drive(1, 1, 0, 0, 8'hC3); push_pid(8'hC3);
    drive(1, 0, 0, 0, 8'h11);
    drive(1, 0, 0, 0, 8'h22);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("midrst_outs", int'({pid, byte_count, pkt_ok}), 0);
    idle(1);
    send_short(8'hD2, 0, 0);
    idle(1);

    // eop, err and sop-less bytes in IDLE are ignored
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h00);
    drive(1, 0, 0, 0, 8'hC3);
    idle(4);

    chk("outq_empty", outq.size(), 0);
    chk("pidq_empty", pidq.size(), 0);
    chk("doneq_empty", doneq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
